// File: rtl/mem_arbiter_if.sv
// Requester (C, D) and memory-macro signals of mem_arbiter bundled as one interface.
// MEM_ARB_ADDR_CHECK_EN adds the per-port err responses.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_c_req, i_c_we;
  logic [ADDR_W-1:0] i_c_addr;
  logic [DATA_W-1:0] i_c_wdata;
  logic [BE_W-1:0]   i_c_be;
  logic              o_c_gnt, o_c_rvalid;
  logic [DATA_W-1:0] o_c_rdata;

  logic              i_d_req, i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [BE_W-1:0]   i_d_be;
  logic              o_d_gnt, o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_m_en, o_m_we;
  logic [ADDR_W-1:0] o_m_addr;
  logic [DATA_W-1:0] o_m_wdata;
  logic [BE_W-1:0]   o_m_be;
  logic [DATA_W-1:0] i_m_rdata;

`ifdef MEM_ARB_ADDR_CHECK_EN
  logic              o_c_err, o_d_err;
`endif

  modport slave (
`ifdef MEM_ARB_ADDR_CHECK_EN
    output o_c_err, o_d_err,
`endif
    input  i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_be,
    output o_c_gnt, o_c_rvalid, o_c_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_m_en, o_m_we, o_m_addr, o_m_wdata, o_m_be,
    input  i_m_rdata
  );

  modport master (
`ifdef MEM_ARB_ADDR_CHECK_EN
    input  o_c_err, o_d_err,
`endif
    output i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_be,
    input  o_c_gnt, o_c_rvalid, o_c_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_m_en, o_m_we, o_m_addr, o_m_wdata, o_m_be,
    output i_m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (core C, DMA D) arbiter in front of a single-port fixed-latency memory.
// Optional MEM_ARB_ADDR_CHECK_EN: out-of-range/misaligned grants skip memory and respond with err.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
`ifdef MEM_ARB_ADDR_CHECK_EN
  , parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_4000
`endif
) (
  input logic          i_clk,
  input logic          i_rstn,
  mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] SMAX    = 4'(STARVE_MAX);
  localparam logic [2:0] LAT     = 3'(MEM_LAT);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  logic [1:0] state;
  logic [2:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       owner_d, owner_we, owner_bad;

  req_t c_r, d_r, win_r;
  logic idle, grant, pick_d, win_bad, mem_act, resp;
  logic [DATA_W-1:0] rdata;

  assign c_r = {bus.i_c_we, bus.i_c_addr, bus.i_c_wdata, bus.i_c_be};
  assign d_r = {bus.i_d_we, bus.i_d_addr, bus.i_d_wdata, bus.i_d_be};

  // Gating with i_rstn keeps gnt and the memory strobe low while reset is held.
  assign idle   = (state == ST_IDLE) && i_rstn;
  assign grant  = idle && (bus.i_c_req || bus.i_d_req);
  assign pick_d = bus.i_d_req && (!bus.i_c_req || starve_cnt == SMAX);
  assign win_r  = pick_d ? d_r : c_r;

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign win_bad = (win_r.addr >= ADDR_LIMIT) || ((win_r.addr & ADDR_W'(BE_W - 1)) != '0);
`else
  assign win_bad = 1'b0;
`endif

  assign mem_act = grant && !win_bad;

  assign bus.o_c_gnt   = grant && !pick_d;
  assign bus.o_d_gnt   = grant && pick_d;
  assign bus.o_m_en    = mem_act;
  assign bus.o_m_we    = mem_act && win_r.we;
  assign bus.o_m_addr  = mem_act ? win_r.addr  : '0;
  assign bus.o_m_wdata = mem_act ? win_r.wdata : '0;
  assign bus.o_m_be    = mem_act ? win_r.be    : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      owner_we   <= 1'b0;
      owner_bad  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (grant) begin
          owner_d   <= pick_d;
          owner_we  <= win_r.we;
          owner_bad <= win_bad;
          wait_cnt  <= LAT;
          state     <= (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
          if (!pick_d && bus.i_d_req)
            starve_cnt <= (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 4'd1;
          else
            starve_cnt <= '0;
        end
        // Leaving WAIT as the counter reaches 1 lands RESP exactly MEM_LAT cycles after gnt.
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd2) state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign resp  = (state == ST_RESP);
  assign rdata = (!owner_we && !owner_bad) ? bus.i_m_rdata : '0;

  assign bus.o_c_rvalid = resp && !owner_d;
  assign bus.o_d_rvalid = resp && owner_d;
  assign bus.o_c_rdata  = bus.o_c_rvalid ? rdata : '0;
  assign bus.o_d_rdata  = bus.o_d_rvalid ? rdata : '0;

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign bus.o_c_err = bus.o_c_rvalid && owner_bad;
  assign bus.o_d_err = bus.o_d_rvalid && owner_bad;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. Instances with MEM_LAT=1 (bus1) and MEM_LAT=3 (bus3).
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 4, LAT1 = 1;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX))
    dut1 (.i_clk(i_clk), .i_rstn(i_rstn), .bus(bus1));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX))
    dut3 (.i_clk(i_clk), .i_rstn(i_rstn), .bus(bus3));

  // Memory macro model: 16 words, reads return data MEM_LAT cycles after o_m_en, junk otherwise.
  logic [31:0] mem [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] p1;
  logic [31:0] p3 [3];

  always @(posedge i_clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (bus1.o_m_en && bus1.o_m_we)
      for (int b = 0; b < 4; b++)
        if (bus1.o_m_be[b]) mem[bus1.o_m_addr[5:2]][8*b +: 8] <= bus1.o_m_wdata[8*b +: 8];
    p1    <= (bus1.o_m_en && !bus1.o_m_we) ? mem[bus1.o_m_addr[5:2]] : $urandom;
    p3[0] <= (bus3.o_m_en && !bus3.o_m_we) ? mem[bus3.o_m_addr[5:2]] : $urandom;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.i_m_rdata = p1;
  assign bus3.i_m_rdata = p3[2];

  function automatic logic [137:0] outs1();
    return {bus1.o_c_gnt, bus1.o_d_gnt, bus1.o_c_rvalid, bus1.o_d_rvalid, bus1.o_c_rdata,
            bus1.o_d_rdata, bus1.o_m_en, bus1.o_m_we, bus1.o_m_addr, bus1.o_m_wdata, bus1.o_m_be};
  endfunction
  function automatic logic [137:0] outs3();
    return {bus3.o_c_gnt, bus3.o_d_gnt, bus3.o_c_rvalid, bus3.o_d_rvalid, bus3.o_c_rdata,
            bus3.o_d_rdata, bus3.o_m_en, bus3.o_m_we, bus3.o_m_addr, bus3.o_m_wdata, bus3.o_m_be};
  endfunction

  task automatic idle_inputs();
    bus1.i_c_req = 0; bus1.i_c_we = 0; bus1.i_c_addr = '0; bus1.i_c_wdata = '0; bus1.i_c_be = '0;
    bus1.i_d_req = 0; bus1.i_d_we = 0; bus1.i_d_addr = '0; bus1.i_d_wdata = '0; bus1.i_d_be = '0;
    bus3.i_c_req = 0; bus3.i_c_we = 0; bus3.i_c_addr = '0; bus3.i_c_wdata = '0; bus3.i_c_be = '0;
    bus3.i_d_req = 0; bus3.i_d_we = 0; bus3.i_d_addr = '0; bus3.i_d_wdata = '0; bus3.i_d_be = '0;
  endtask

  task automatic load_word(input int idx, input logic [31:0] v);
    @(negedge i_clk); ld_en = 1; ld_idx = 4'(idx); ld_data = v;
    @(negedge i_clk); ld_en = 0;
  endtask

  task automatic pulse_reset();
    @(negedge i_clk); i_rstn = 0;
    @(negedge i_clk); i_rstn = 1;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rstn = 0; bus1.i_c_req = 1; bus1.i_c_addr = 32'h10; bus3.i_d_req = 1;
    #1;
    checks++; if (outs1() !== '0) begin failures++; $display("FAIL reset_outs1: got %h expected 0", outs1()); end
    checks++; if (outs3() !== '0) begin failures++; $display("FAIL reset_outs3: got %h expected 0", outs3()); end
    @(negedge i_clk); idle_inputs(); i_rstn = 1;
    #1;
    checks++; if (outs1() !== '0) begin failures++; $display("FAIL idle_outs: got %h expected 0", outs1()); end
  endtask

  task automatic test_c_read();
    load_word(4, 32'hDEADBEEF);
    @(negedge i_clk);
    bus1.i_c_req = 1; bus1.i_c_we = 0; bus1.i_c_addr = 32'h10; bus1.i_c_be = 4'hF;
    #1;
    checks++; if ({bus1.o_c_gnt, bus1.o_d_gnt, bus1.o_m_en, bus1.o_m_we, bus1.o_m_addr} !== {4'b1010, 32'h10}) begin
      failures++; $display("FAIL c_read_gnt: got %b%b%b%b %h expected 1010 10", bus1.o_c_gnt, bus1.o_d_gnt,
                           bus1.o_m_en, bus1.o_m_we, bus1.o_m_addr); end
    @(negedge i_clk);
    checks++; if ({bus1.o_c_rvalid, bus1.o_c_rdata, bus1.o_c_gnt, bus1.o_m_en} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
      failures++; $display("FAIL c_read_resp: got rv=%b rdata=%h gnt=%b en=%b expected 1 deadbeef 0 0",
                           bus1.o_c_rvalid, bus1.o_c_rdata, bus1.o_c_gnt, bus1.o_m_en); end
    bus1.i_c_req = 0;
    @(negedge i_clk);
    checks++; if (outs1() !== '0) begin failures++; $display("FAIL c_read_idle: got %h expected 0", outs1()); end
  endtask

  task automatic test_d_write();
    @(negedge i_clk);
    bus1.i_d_req = 1; bus1.i_d_we = 1; bus1.i_d_addr = 32'h20; bus1.i_d_wdata = 32'h12345678; bus1.i_d_be = 4'b0011;
    #1;
    checks++; if ({bus1.o_d_gnt, bus1.o_c_gnt, bus1.o_m_en, bus1.o_m_we, bus1.o_m_addr, bus1.o_m_wdata, bus1.o_m_be}
                  !== {4'b1011, 32'h20, 32'h12345678, 4'b0011}) begin
      failures++; $display("FAIL d_write_gnt: got gnt=%b en=%b we=%b a=%h wd=%h be=%b expected 1 1 1 20 12345678 0011",
                           bus1.o_d_gnt, bus1.o_m_en, bus1.o_m_we, bus1.o_m_addr, bus1.o_m_wdata, bus1.o_m_be); end
    @(negedge i_clk);
    checks++; if ({bus1.o_d_rvalid, bus1.o_d_rdata, bus1.o_c_rvalid, bus1.o_c_rdata} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL d_write_resp: got d_rv=%b d_rd=%h c_rv=%b c_rd=%h expected 1 0 0 0",
                           bus1.o_d_rvalid, bus1.o_d_rdata, bus1.o_c_rvalid, bus1.o_c_rdata); end
    bus1.i_d_req = 0; bus1.i_d_we = 0;
    @(negedge i_clk);
    checks++; if (bus1.o_d_rvalid !== 1'b0) begin failures++; $display("FAIL d_write_pulse: got %b expected 0", bus1.o_d_rvalid); end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_seq;
    int n, last;
    exp_seq = 10'b10000_10000;  // bit n = 1 means grant n goes to D
    n = 0; last = 0;
    pulse_reset();
    @(negedge i_clk);
    bus1.i_c_req = 1; bus1.i_c_addr = 32'h0; bus1.i_d_req = 1; bus1.i_d_addr = 32'h4;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      if (cyc > 0) @(negedge i_clk);
      #1;
      if (bus1.o_c_gnt && bus1.o_d_gnt) begin
        checks++; failures++; $display("FAIL starve_two_gnt: got both expected one");
      end else if (bus1.o_c_gnt || bus1.o_d_gnt) begin
        checks++; if (bus1.o_d_gnt !== exp_seq[n]) begin failures++;
          $display("FAIL starve_order[%0d]: got d_gnt=%b expected %b", n, bus1.o_d_gnt, exp_seq[n]); end
        if (n > 0) begin checks++; if (cyc - last != LAT1 + 1) begin failures++;
          $display("FAIL starve_gap[%0d]: got %0d expected %0d", n, cyc - last, LAT1 + 1); end end
        last = cyc; n++;
      end
    end
    checks++; if (n != 10) begin failures++; $display("FAIL starve_timeout: got %0d grants expected 10", n); end
    bus1.i_c_req = 0; bus1.i_d_req = 0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_mem_lat3();
    @(negedge i_clk);
    bus3.i_c_req = 1; bus3.i_c_we = 0; bus3.i_c_addr = 32'h10; bus3.i_c_be = 4'hF;
    #1;
    checks++; if ({bus3.o_c_gnt, bus3.o_m_en, bus3.o_m_addr} !== {2'b11, 32'h10}) begin failures++;
      $display("FAIL lat3_gnt: got gnt=%b en=%b a=%h expected 1 1 10", bus3.o_c_gnt, bus3.o_m_en, bus3.o_m_addr); end
    bus3.i_d_req = 1; bus3.i_d_addr = 32'h10; bus3.i_d_be = 4'hF;
    for (int k = 1; k <= 2; k++) begin
      @(negedge i_clk);
      if (k == 1) bus3.i_c_req = 0;
      #1;
      checks++; if (outs3() !== '0) begin failures++; $display("FAIL lat3_wait%0d: got %h expected 0", k, outs3()); end
    end
    @(negedge i_clk); #1;
    checks++; if ({bus3.o_c_rvalid, bus3.o_c_rdata, bus3.o_c_gnt, bus3.o_d_gnt, bus3.o_d_rvalid, bus3.o_m_en}
                  !== {1'b1, 32'hDEADBEEF, 4'b0000}) begin failures++;
      $display("FAIL lat3_resp: got rv=%b rd=%h gnt=%b%b d_rv=%b en=%b expected 1 deadbeef 00 0 0",
               bus3.o_c_rvalid, bus3.o_c_rdata, bus3.o_c_gnt, bus3.o_d_gnt, bus3.o_d_rvalid, bus3.o_m_en); end
    @(negedge i_clk); #1;
    checks++; if ({bus3.o_d_gnt, bus3.o_m_en} !== 2'b11) begin failures++;
      $display("FAIL lat3_b2b_gnt: got d_gnt=%b en=%b expected 1 1", bus3.o_d_gnt, bus3.o_m_en); end
    @(negedge i_clk); bus3.i_d_req = 0;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if ({bus3.o_d_rvalid, bus3.o_d_rdata, bus3.o_c_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin failures++;
      $display("FAIL lat3_d_resp: got rv=%b rd=%h c_rv=%b expected 1 deadbeef 0", bus3.o_d_rvalid, bus3.o_d_rdata, bus3.o_c_rvalid); end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 0;
    @(negedge i_clk);
    bus3.i_d_req = 1; bus3.i_d_we = 0; bus3.i_d_addr = 32'h10; bus3.i_d_be = 4'hF;
    #1;
    checks++; if (bus3.o_d_gnt !== 1'b1) begin failures++; $display("FAIL rst_mid_gnt: got %b expected 1", bus3.o_d_gnt); end
    @(negedge i_clk);
    bus3.i_d_req = 0; i_rstn = 0;
    #1;
    checks++; if (outs3() !== '0) begin failures++; $display("FAIL rst_mid_outs: got %h expected 0", outs3()); end
    @(negedge i_clk); i_rstn = 1;
    repeat (6) begin
      @(negedge i_clk); #1;
      if (bus3.o_d_rvalid !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rst_mid_dropped: got rvalid=1 expected none"); end
    @(negedge i_clk);
    bus3.i_c_req = 1; bus3.i_c_addr = 32'h10; bus3.i_c_be = 4'hF;
    #1;
    checks++; if ({bus3.o_c_gnt, bus3.o_m_en} !== 2'b11) begin failures++;
      $display("FAIL rst_mid_regrant: got gnt=%b en=%b expected 1 1", bus3.o_c_gnt, bus3.o_m_en); end
    @(negedge i_clk); bus3.i_c_req = 0;
    repeat (4) @(negedge i_clk);
  endtask

`ifdef MEM_ARB_ADDR_CHECK_EN
  task automatic test_addr_check();
    logic [31:0] addrs [3];
    logic        bad;
    addrs[0] = 32'h4000; addrs[1] = 32'h0002; addrs[2] = 32'h3FFC;
    load_word(15, 32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      bad = (i != 2);
      @(negedge i_clk);
      bus1.i_c_req = 1; bus1.i_c_we = 0; bus1.i_c_addr = addrs[i]; bus1.i_c_be = 4'hF;
      #1;
      checks++; if ({bus1.o_c_gnt, bus1.o_m_en, bus1.o_c_err} !== {1'b1, !bad, 1'b0}) begin failures++;
        $display("FAIL addr_chk_gnt[%0d]: got gnt=%b en=%b err=%b expected 1 %b 0", i, bus1.o_c_gnt, bus1.o_m_en, bus1.o_c_err, !bad); end
      @(negedge i_clk);
      checks++; if ({bus1.o_c_rvalid, bus1.o_c_err, bus1.o_c_rdata} !== {1'b1, bad, bad ? 32'h0 : 32'h0BADF00D}) begin failures++;
        $display("FAIL addr_chk_resp[%0d]: got rv=%b err=%b rd=%h expected 1 %b", i, bus1.o_c_rvalid, bus1.o_c_err, bus1.o_c_rdata, bad); end
      bus1.i_c_req = 0;
    end
    @(negedge i_clk);
  endtask
`endif

  // Transaction-level reference: the arbiter is free again LAT+1 cycles after each grant,
  // winner chosen by the starvation rule, response due LAT cycles after the grant.
  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] v, resp_data, wd, ad;
    logic [69:0] exp_m, act_m;
    logic [3:0]  be;
    logic        we, win_d, resp_d, exp_cg, exp_dg, last_cg, last_dg;
    int starve, free_at, resp_at;
    for (int i = 0; i < 16; i++) begin v = $urandom; load_word(i, v); ref_mem[i] = v; end
    pulse_reset();
    starve = 0; free_at = 0; resp_at = -1; resp_d = 0; resp_data = '0; last_cg = 0; last_dg = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge i_clk);
      if (last_cg) bus1.i_c_req = 0;
      if (last_dg) bus1.i_d_req = 0;
      if (!bus1.i_c_req && $urandom_range(0, 3) != 0) begin
        bus1.i_c_req = 1; bus1.i_c_we = 1'($urandom_range(0, 1)); bus1.i_c_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus1.i_c_wdata = $urandom; bus1.i_c_be = 4'($urandom_range(0, 15));
      end
      if (!bus1.i_d_req && $urandom_range(0, 3) != 0) begin
        bus1.i_d_req = 1; bus1.i_d_we = 1'($urandom_range(0, 1)); bus1.i_d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus1.i_d_wdata = $urandom; bus1.i_d_be = 4'($urandom_range(0, 15));
      end
      #1;
      exp_cg = 0; exp_dg = 0; exp_m = '0;
      if (cyc >= free_at && (bus1.i_c_req || bus1.i_d_req)) begin
        win_d = bus1.i_d_req && (!bus1.i_c_req || starve == SMAX);
        exp_cg = !win_d; exp_dg = win_d;
        we = win_d ? bus1.i_d_we : bus1.i_c_we;
        ad = win_d ? bus1.i_d_addr : bus1.i_c_addr;
        wd = win_d ? bus1.i_d_wdata : bus1.i_c_wdata;
        be = win_d ? bus1.i_d_be : bus1.i_c_be;
        exp_m = {1'b1, we, ad, wd, be};
        resp_at = cyc + LAT1; resp_d = win_d; resp_data = we ? 32'h0 : ref_mem[ad[5:2]];
        if (we) for (int b = 0; b < 4; b++) if (be[b]) ref_mem[ad[5:2]][8*b +: 8] = wd[8*b +: 8];
        starve = (!win_d && bus1.i_d_req) ? ((starve == SMAX) ? SMAX : starve + 1) : 0;
        free_at = cyc + LAT1 + 1;
      end
      checks++; if ({bus1.o_c_gnt, bus1.o_d_gnt} !== {exp_cg, exp_dg}) begin failures++;
        $display("FAIL rnd_gnt@%0d: got %b%b expected %b%b", cyc, bus1.o_c_gnt, bus1.o_d_gnt, exp_cg, exp_dg); end
      act_m = {bus1.o_m_en, bus1.o_m_we, bus1.o_m_addr, bus1.o_m_wdata, bus1.o_m_be};
      checks++; if (act_m !== exp_m) begin failures++;
        $display("FAIL rnd_mem@%0d: got %h expected %h", cyc, act_m, exp_m); end
      checks++; if ({bus1.o_c_rvalid, bus1.o_c_rdata} !== {(cyc == resp_at) && !resp_d, ((cyc == resp_at) && !resp_d) ? resp_data : 32'h0}) begin
        failures++; $display("FAIL rnd_c_resp@%0d: got %b %h expected %b %h", cyc, bus1.o_c_rvalid, bus1.o_c_rdata,
                             (cyc == resp_at) && !resp_d, resp_data); end
      checks++; if ({bus1.o_d_rvalid, bus1.o_d_rdata} !== {(cyc == resp_at) && resp_d, ((cyc == resp_at) && resp_d) ? resp_data : 32'h0}) begin
        failures++; $display("FAIL rnd_d_resp@%0d: got %b %h expected %b %h", cyc, bus1.o_d_rvalid, bus1.o_d_rdata,
                             (cyc == resp_at) && resp_d, resp_data); end
      last_cg = exp_cg; last_dg = exp_dg;
    end
    @(negedge i_clk); idle_inputs();
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_c_read();
    test_d_write();
    test_starvation();
    test_mem_lat3();
    test_reset_mid();
`ifdef MEM_ARB_ADDR_CHECK_EN
    test_addr_check();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two requesters: the multicycle core's memory port (port C: fetch and load/store) and a DMA/debug loader port (port D).
- Sits between the core datapath's address mux and the memory macro.
- Sequences one transaction at a time: grant, fixed wait, then a response pulse.
- Fixed priority to C, with starvation protection for D.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..7.
- STARVE_MAX, 4, consecutive C grants allowed while D waits; legal range 1..15.
- ADDR_LIMIT, 32'h0000_4000, first illegal byte address (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset
- i_c_req  in  1  C request; held until granted
- i_c_we  in  1  C write
- i_c_addr  in  ADDR_W  C address
- i_c_wdata  in  DATA_W  C write data
- i_c_be  in  DATA_W/8  C byte enables
- o_c_gnt  out  1  C granted (combinational)
- o_c_rvalid  out  1  C response pulse
- o_c_rdata  out  DATA_W  C read data
- i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be, o_d_gnt, o_d_rvalid, o_d_rdata: same as the C set, for port D
- o_m_en  out  1  memory access strobe
- o_m_we  out  1  memory write
- o_m_addr  out  ADDR_W  memory address
- o_m_wdata  out  DATA_W  memory write data
- o_m_be  out  DATA_W/8  memory byte enables
- i_m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after o_m_en

Behaviour:
- Reset: i_rstn is asynchronous, active-low; clock is i_clk.
  - State goes to IDLE; wait counter, starvation counter and owner flag are cleared.
  - All outputs are 0.
  - Reset asserted mid-transaction drops that transaction: no rvalid is ever produced for it.
- Requester contract: req, we, addr, wdata and be stay stable from req assertion through the gnt cycle. Req may drop only after gnt.
- State IDLE:
  - If neither request is pending, all outputs stay 0.
  - Winner selection: if both request, C wins unless starve_cnt == STARVE_MAX, in which case D wins. A lone requester always wins.
  - In the same cycle: assert the winner's gnt; drive o_m_en=1 and o_m_we/addr/wdata/be from the winner; record the owner; load wait_cnt=MEM_LAT; go to WAIT.
- starve_cnt update on each grant:
  - C granted while i_d_req=1: increment, saturating at STARVE_MAX.
  - D granted, or C granted with D idle: clear.
- State WAIT:
  - All memory outputs are 0.
  - wait_cnt decrements each cycle. On the transition to 1, go to RESP.
  - For MEM_LAT=1, go directly to RESP on the next cycle.
- State RESP:
  - Exactly one cycle.
  - The owner's rvalid=1 and rdata=i_m_rdata, for reads and writes alike. For writes the rdata value is don't-care and is driven 0.
  - The non-owner's rvalid stays 0.
  - Next state is IDLE; no grant is issued in the RESP cycle.
- Rvalid timing: rvalid rises exactly MEM_LAT cycles after the gnt cycle.
- Throughput: one transaction per MEM_LAT+1 cycles. A back-to-back grant is issued in the IDLE cycle right after RESP.
- Non-owner rdata is 0 at all times.
- Gnt is never asserted outside IDLE; at most one gnt is high per cycle.

Optional Feature:
- Macro: MEM_ARB_ADDR_CHECK_EN.
- When defined:
  - Adds outputs o_c_err and o_d_err (1 bit each).
  - A granted request with addr >= ADDR_LIMIT, or with addr not aligned to DATA_W/8, is still granted but o_m_en stays 0 (no memory access).
  - Its response still arrives at the normal rvalid cycle, with err=1 and rdata=0.
  - err is 0 for legal accesses and whenever rvalid=0.
- When undefined: no err ports, no address check; every grant accesses memory.

Test Plan:
- Reset, then C read at addr 0x10 with memory word 0xDEADBEEF, MEM_LAT=1 -> o_c_gnt and o_m_en in cycle 0; o_c_rvalid=1 with rdata 0xDEADBEEF in cycle 1; IDLE in cycle 2.
- D write to 0x20, data 0x12345678, be=4'b0011 -> o_m_we=1, o_m_be=4'b0011 in the grant cycle; o_d_rvalid pulse one cycle later; o_c_rvalid stays 0.
- C and D both requesting continuously, STARVE_MAX=4 -> grant order C,C,C,C,D,C,C,C,C,D; each grant is MEM_LAT+1 cycles apart.
- MEM_LAT=3, single C read -> rvalid exactly 3 cycles after gnt; memory outputs 0 during WAIT; no gnt issued during WAIT or RESP even with D pending.
- Reset asserted in the WAIT cycle of a D read -> all outputs 0 immediately; no o_d_rvalid after reset release; the next request is granted from IDLE.
- With MEM_ARB_ADDR_CHECK_EN, C read at 0x4000 and at 0x0002 -> o_m_en=0; o_c_rvalid with o_c_err=1 and rdata 0; a read at 0x3FFC gives err=0.
